// File: rtl/cpu_wb_pkg.sv
// Shared widths and response bundle for the Wishbone instruction-fetch master.
package cpu_wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_ADDR_W-1:0] addr;
    logic                 err;
  } fetch_rsp_t;

endpackage

// File: rtl/cpu_wb_fetch_addr_fifo.sv
// Address FIFO tracking issued fetch addresses until their termination.
module cpu_wb_fetch_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  assign wr_d    = push_i ? wr_q + 1'b1 : wr_q;
  assign rd_d    = pop_i  ? rd_q + 1'b1 : rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cpu_wb_fetch_pipe_master.sv
// Pipelined Wishbone B4 fetch master with flush/drop tracking.
// Define CPU_FETCH_WB_ERR_EN to let ERR_I terminate reads and report errors.
module cpu_wb_fetch_pipe_master
  import cpu_wb_pkg::*;
#(
  parameter int WISHBONE_ADDR_WIDTH = WB_ADDR_W,
  parameter int WISHBONE_BUS_WIDTH  = WB_DATA_W,
  parameter int MAX_OUTSTANDING     = 4
) (
  input  logic                           CLK_I,
  input  logic                           RST_NI,
  input  logic                           CPU_FETCH_CMD_VALID_I,
  output logic                           CPU_FETCH_CMD_READY_O,
  input  logic [WISHBONE_ADDR_WIDTH-1:0] CPU_FETCH_CMD_ADDR_I,
  input  logic                           CPU_FETCH_FLUSH_I,
  output logic [WISHBONE_BUS_WIDTH-1:0]  CPU_FETCH_CMD_RDATA_O,
  output logic [WISHBONE_ADDR_WIDTH-1:0] CPU_FETCH_CMD_RADDR_O,
  output logic                           CPU_FETCH_CMD_RDATA_VALID_O,
  output logic                           CPU_FETCH_CMD_RDATA_ERR_O,
  output logic                           CPU_FETCH_WBM_CYC_O,
  output logic                           CPU_FETCH_WBM_STB_O,
  output logic [WISHBONE_ADDR_WIDTH-1:0] CPU_FETCH_WBM_ADR_O,
  input  logic [WISHBONE_BUS_WIDTH-1:0]  CPU_FETCH_WBM_DAT_I,
  input  logic                           CPU_FETCH_WBM_ACK_I,
  input  logic                           CPU_FETCH_WBM_ERR_I,
  input  logic                           CPU_FETCH_WBM_STALL_I
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW:0] MAXV = (CW+1)'(MAX_OUTSTANDING);

  logic                           stb_q, stb_d;
  logic [WISHBONE_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [CW-1:0]                  drop_q, drop_d;
  logic                           rv_q, err_q;
  logic [WISHBONE_BUS_WIDTH-1:0]  rdata_q;
  logic [WISHBONE_ADDR_WIDTH-1:0] raddr_q;
  logic [WISHBONE_ADDR_WIDTH-1:0] head;
  logic [CW:0]                    t_tot;
  logic fifo_full, fifo_empty;
  logic term_raw, term_err, term;
  logic ready, accept, issue, rsp_fire;

`ifdef CPU_FETCH_WB_ERR_EN
  assign term_raw = CPU_FETCH_WBM_ACK_I | CPU_FETCH_WBM_ERR_I;
  assign term_err = CPU_FETCH_WBM_ERR_I;
`else
  logic unused_err;
  assign unused_err = CPU_FETCH_WBM_ERR_I;
  assign term_raw   = CPU_FETCH_WBM_ACK_I;
  assign term_err   = 1'b0;
`endif

  // Stray terminations with nothing in flight are ignored.
  assign term   = term_raw && !fifo_empty;
  assign issue  = stb_q && !CPU_FETCH_WBM_STALL_I;
  assign t_tot  = {1'b0, cnt_q} + {{CW{1'b0}}, stb_q};
  assign ready  = RST_NI && !CPU_FETCH_FLUSH_I && !fifo_full &&
                  (!stb_q || !CPU_FETCH_WBM_STALL_I) &&
                  (t_tot < MAXV);
  assign accept = CPU_FETCH_CMD_VALID_I && ready;

  assign cnt_d = cnt_q + {{(CW-1){1'b0}}, issue}
                       - {{(CW-1){1'b0}}, term};
  assign rsp_fire = term && !CPU_FETCH_FLUSH_I && (drop_q == '0);

  always_comb begin
    stb_d  = stb_q;
    adr_d  = adr_q;
    drop_d = drop_q;
    if (CPU_FETCH_FLUSH_I) begin
      stb_d  = 1'b0;
      drop_d = cnt_d;
    end else begin
      if (accept) begin
        stb_d = 1'b1;
        adr_d = CPU_FETCH_CMD_ADDR_I;
      end else if (issue) begin
        stb_d = 1'b0;
      end
      if (term && drop_q != '0) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      stb_q   <= 1'b0;
      adr_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      raddr_q <= '0;
    end else begin
      stb_q  <= stb_d;
      adr_q  <= adr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      rv_q   <= rsp_fire;
      err_q  <= rsp_fire & term_err;
      if (rsp_fire) begin
        rdata_q <= CPU_FETCH_WBM_DAT_I;
        raddr_q <= head;
      end
    end
  end

  cpu_wb_fetch_addr_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (WISHBONE_ADDR_WIDTH)
  ) u_fifo (
    .clk_i   (CLK_I),
    .rst_ni  (RST_NI),
    .push_i  (issue),
    .pop_i   (term),
    .data_i  (adr_q),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign CPU_FETCH_CMD_READY_O       = ready;
  assign CPU_FETCH_CMD_RDATA_O       = rdata_q;
  assign CPU_FETCH_CMD_RADDR_O       = raddr_q;
  assign CPU_FETCH_CMD_RDATA_VALID_O = rv_q;
  assign CPU_FETCH_CMD_RDATA_ERR_O   = err_q;
  assign CPU_FETCH_WBM_STB_O         = stb_q;
  assign CPU_FETCH_WBM_ADR_O         = adr_q;
  assign CPU_FETCH_WBM_CYC_O         = stb_q || (cnt_q != '0);

endmodule

// File: doc/cpu_wb_fetch_pipe_master.md
CPU_WB_FETCH_PIPE_MASTER -- requirements
Module: cpu_wb_fetch_pipe_master

Interface
REQ-001 The block SHALL have parameter WISHBONE_ADDR_WIDTH, default 32, giving the address width.
REQ-002 The block SHALL have parameter WISHBONE_BUS_WIDTH, default 32, giving the data width.
REQ-003 The block SHALL have parameter MAX_OUTSTANDING, default 4, giving the maximum number of in-flight reads; it is a power of 2 and at least 2.
REQ-004 CLK_I  in  1  sole clock, rising edge.
REQ-005 RST_NI  in  1  reset, asynchronous assert, active-low.
REQ-006 CPU_FETCH_CMD_VALID_I  in  1  fetch request valid.
REQ-007 CPU_FETCH_CMD_READY_O  out  1  request accepted when high with VALID.
REQ-008 CPU_FETCH_CMD_ADDR_I  in  WISHBONE_ADDR_WIDTH  fetch address.
REQ-009 CPU_FETCH_FLUSH_I  in  1  redirect: abandon every un-returned request.
REQ-010 CPU_FETCH_CMD_RDATA_O  out  WISHBONE_BUS_WIDTH  returned instruction word.
REQ-011 CPU_FETCH_CMD_RADDR_O  out  WISHBONE_ADDR_WIDTH  address of the returned word.
REQ-012 CPU_FETCH_CMD_RDATA_VALID_O  out  1  response strobe, one cycle per response; no backpressure.
REQ-013 CPU_FETCH_CMD_RDATA_ERR_O  out  1  bus error on the returned word.
REQ-014 CPU_FETCH_WBM_CYC_O, CPU_FETCH_WBM_STB_O  out  1 each  Wishbone B4 pipelined cycle and strobe.
REQ-015 CPU_FETCH_WBM_ADR_O  out  WISHBONE_ADDR_WIDTH  bus address.
REQ-016 CPU_FETCH_WBM_DAT_I  in  WISHBONE_BUS_WIDTH  read data.
REQ-017 CPU_FETCH_WBM_ACK_I, CPU_FETCH_WBM_ERR_I, CPU_FETCH_WBM_STALL_I  in  1 each  slave terminations and stall.

Function
REQ-018 A request SHALL be accepted on a cycle where VALID, READY and !FLUSH_I are all high.
REQ-019 READY SHALL equal !FLUSH_I && (!STB_O || !STALL_I) && (T < MAX_OUTSTANDING), where T = outstanding + STB_O.
REQ-020 READY SHALL NOT count a same-cycle ACK/ERR as freeing a slot.
REQ-021 An accepted request SHALL drive STB_O=1 and ADR_O=address on the next cycle.
REQ-022 STB_O and ADR_O SHALL hold while STALL_I=1.
REQ-023 The request SHALL be issued on the cycle where STB_O && !STALL_I; issue increments outstanding and pushes ADR_O into the address FIFO.
REQ-024 Back-to-back accepts SHALL sustain one issue per cycle when STALL_I=0.
REQ-025 CYC_O SHALL be high whenever STB_O=1 or outstanding>0, and low otherwise.
REQ-026 ACK_I or ERR_I SHALL pop the FIFO and decrement outstanding; a simultaneous issue and termination leaves outstanding unchanged.
REQ-027 A termination received while outstanding=0 SHALL be ignored.
REQ-028 A non-discarded termination SHALL produce RDATA_VALID_O=1 exactly one cycle later, with registered DAT_I, the popped FIFO address, and ERR_O=ERR_I.
REQ-029 Responses SHALL return in issue order.
REQ-030 FLUSH_I=1 SHALL drop STB_O the next cycle, withdrawing any un-issued request.
REQ-031 FLUSH_I=1 SHALL set drop_cnt to the outstanding count after that cycle's issue and termination.
REQ-032 A termination in the flush cycle SHALL be discarded.
REQ-033 While drop_cnt>0, each termination SHALL pop the FIFO, decrement drop_cnt and assert no RDATA_VALID_O.
REQ-034 A new request MAY be accepted from the cycle after flush; its responses follow the discarded ones.
REQ-035 A repeated FLUSH_I SHALL reload drop_cnt by the same rule.

Reset
REQ-036 On RST_NI low, STB_O, RDATA_VALID_O, RDATA_ERR_O, outstanding, drop_cnt and FIFO pointers SHALL be 0.
REQ-037 CYC_O SHALL be 0 during reset; READY SHALL be 0 while RST_NI is low.
REQ-038 RDATA_O, RADDR_O and ADR_O SHALL be 0 during reset.
REQ-039 Reset mid-transaction SHALL abandon all in-flight state; late terminations after release obey REQ-027.

Configuration
REQ-040 With macro CPU_FETCH_WB_ERR_EN defined, ERR_I terminates a read and propagates to RDATA_ERR_O.
REQ-041 With CPU_FETCH_WB_ERR_EN undefined, ERR_I SHALL be ignored entirely and RDATA_ERR_O SHALL be constant 0.

Structure
REQ-042 Package cpu_wb_pkg SHALL hold the address/data width defaults and a fetch response struct {data, addr, err}.
REQ-043 The address FIFO SHALL be sub-module cpu_wb_fetch_addr_fifo (depth MAX_OUTSTANDING, push/pop, full/empty), instantiated once.

Verification
REQ-044 Scenario: STALL_I=0, ACK one cycle after issue, VALID held with addresses 0x0,0x4,0x8,0xC -> one issue per cycle, four RDATA_VALID_O pulses, RADDR_O 0x0,0x4,0x8,0xC in order.
REQ-045 Scenario: STALL_I=1 for 3 cycles with ADR_O=0x100 -> ADR_O/STB_O stable, READY=0 throughout, single issue when stall drops.
REQ-046 Scenario: ACK withheld, MAX_OUTSTANDING=4 -> READY=0 after 4 issues (T=4); first ACK -> READY=1 next cycle.
REQ-047 Scenario: 3 outstanding, FLUSH_I pulse, request 0x200 issued after -> first 3 ACKs give no RDATA_VALID_O; 4th ACK returns RADDR_O=0x200.
REQ-048 Scenario: ERR_I on second of two reads, macro defined -> RDATA_ERR_O=1 on second response only; macro undefined -> ERR_O stays 0 and ERR_I never terminates.
REQ-049 Scenario: RST_NI low mid-burst with 2 outstanding -> CYC_O/STB_O 0 immediately; stray ACK after release produces no response.
